// File: rtl/sobol_seq_ctrl.sv
// Sobol sequence controller.
// An index counter walks 0..len; each accepted beat XORs the direction vector
// selected by the least-significant-zero (LSZ) position of the counter into
// the running sequence value. The output is a valid/ready stream so the
// downstream stochastic-number comparators can stall it.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for iStart; outputs quiet
// RUN   | streaming values, oValid/oBusy high, advancing on iReady
// DONE  | single-cycle oDone pulse after the last accepted beat
module sobol_seq_ctrl #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         iStart,
    input  logic                         iClear,
    input  logic [BITWIDTH-1:0]          iLen,
    input  logic [BITWIDTH*BITWIDTH-1:0] iDirVec,
    input  logic                         iReady,
    output logic [BITWIDTH-1:0]          oSobol,
    output logic                         oValid,
    output logic [LOGBITWIDTH-1:0]       oLszIdx,
    output logic                         oBusy,
    output logic                         oDone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state;
    logic [BITWIDTH-1:0]            cnt;
    logic [BITWIDTH-1:0]            len_reg;
    logic [BITWIDTH*BITWIDTH-1:0]   dir_vec_reg;

    logic [BITWIDTH-1:0]            cnt_inc;
    logic [BITWIDTH-1:0]            dir_sel;
    logic [LOGBITWIDTH-1:0]         lsz_next;
    logic                           beat_acc;
    logic                           last_beat;

    // Index of the lowest zero bit; an all-ones value has none and maps to 0.
    // That only happens on the final beat of a full-period run, where the
    // successor value is never used.
    function automatic logic [LOGBITWIDTH-1:0] lsz_of(input logic [BITWIDTH-1:0] v);
        logic [LOGBITWIDTH-1:0] idx;
        idx = '0;
        for (int i = BITWIDTH - 1; i >= 0; i--) begin
            if (!v[i]) begin
                idx = LOGBITWIDTH'(i);
            end
        end
        return idx;
    endfunction

    assign cnt_inc   = cnt + BITWIDTH'(1);
    assign beat_acc  = oValid & iReady;
    assign last_beat = (cnt == len_reg);

    // Direction vector picked by the registered LSZ index of the current count.
    always_comb begin
        dir_sel = '0;
        for (int k = 0; k < BITWIDTH; k++) begin
            if (oLszIdx == LOGBITWIDTH'(k)) begin
                dir_sel = dir_vec_reg[k*BITWIDTH +: BITWIDTH];
            end
        end
    end

    // LSZ position of the count that follows the current one.
    always_comb begin
        lsz_next = lsz_of(cnt_inc);
    end

    // Sequencer FSM with registered outputs; iClear overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len_reg     <= '0;
            dir_vec_reg <= '0;
            oSobol      <= '0;
            oValid      <= 1'b0;
            oLszIdx     <= '0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
        end else if (iClear) begin
            state   <= IDLE;
            cnt     <= '0;
            oSobol  <= '0;
            oValid  <= 1'b0;
            oLszIdx <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        state       <= RUN;
                        len_reg     <= iLen;
                        dir_vec_reg <= iDirVec;
                        cnt         <= '0;
                        oSobol      <= '0;
                        oLszIdx     <= '0;
                        oValid      <= 1'b1;
                        oBusy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        if (last_beat) begin
                            state  <= DONE;
                            oValid <= 1'b0;
                            oBusy  <= 1'b0;
                            oDone  <= 1'b1;
                        end else begin
                            oSobol  <= oSobol ^ dir_sel;
                            cnt     <= cnt_inc;
                            oLszIdx <= lsz_next;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    oDone  <= 1'b0;
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                    oDone  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_seq_ctrl.sv
// Directed bench for sobol_seq_ctrl (BITWIDTH=4) with hand-computed sequences.
module tb_sobol_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        iStart;
    logic        iClear;
    logic [3:0]  iLen;
    logic [15:0] iDirVec;
    logic        iReady;
    logic [3:0]  oSobol;
    logic        oValid;
    logic [1:0]  oLszIdx;
    logic        oBusy;
    logic        oDone;

    int nvec;
    int nerr;

    // Hand-derived for V = {8,4,2,1} (iDirVec = 16'h1248).
    logic [3:0] exp_seq [16] = '{4'd0, 4'd8, 4'd12, 4'd4, 4'd6, 4'd14, 4'd10, 4'd2,
                                 4'd3, 4'd11, 4'd15, 4'd7, 4'd5, 4'd13, 4'd9, 4'd1};
    logic [1:0] exp_lsz [16] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [31:0] rdy_pat = 32'hB53C_96E1;
    logic [15:0] seen;

    sobol_seq_ctrl #(.BITWIDTH(4), .LOGBITWIDTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iStart  (iStart),
        .iClear  (iClear),
        .iLen    (iLen),
        .iDirVec (iDirVec),
        .iReady  (iReady),
        .oSobol  (oSobol),
        .oValid  (oValid),
        .oLszIdx (oLszIdx),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [3:0] len);
        iLen    = len;
        iDirVec = 16'h1248;
        iStart  = 1'b1;
        tick();
        iStart  = 1'b0;
        iLen    = 4'hA;
        iDirVec = 16'hF0F0;
        chk("first_valid", oValid, 1);
    endtask

    // Streams a started run; optional backpressure, mid-run start glitch, clear.
    task automatic run_beats(input int n, input bit stall, input int glitch_at, input int clear_at);
        int beat;
        int cyc;
        bit cleared;
        beat    = 0;
        cyc     = 0;
        cleared = 0;
        seen    = '0;
        while (beat < n && cyc < 200 && !cleared) begin
            chk("valid", oValid, 1);
            chk("busy", oBusy, 1);
            chk("done_early", oDone, 0);
            chk("sobol", oSobol, exp_seq[beat]);
            chk("lsz", oLszIdx, exp_lsz[beat]);
            iReady = stall ? rdy_pat[cyc % 32] : 1'b1;
            if (beat == glitch_at) begin
                iStart  = 1'b1;
                iLen    = 4'd1;
                iDirVec = 16'h5555;
            end
            iClear = (beat == clear_at);
            if (iReady) seen[exp_seq[beat]] = 1'b1;
            tick();
            iStart = 1'b0;
            if (iClear) begin
                iClear = 1'b0;
                cleared = 1;
                chk("clr_valid", oValid, 0);
                chk("clr_busy", oBusy, 0);
                chk("clr_done", oDone, 0);
                chk("clr_sobol", oSobol, 0);
                tick();
                chk("clr_done2", oDone, 0);
                chk("clr_busy2", oBusy, 0);
            end else begin
                if (iReady) beat++;
                cyc++;
            end
        end
        iReady = 1'b1;
        if (!cleared) begin
            chk("beat_count", beat, n);
            chk("end_valid", oValid, 0);
            chk("end_done", oDone, 1);
            chk("end_busy", oBusy, 0);
            tick();
            chk("idle_done", oDone, 0);
            chk("idle_valid", oValid, 0);
        end
    endtask

    initial begin
        nvec    = 0;
        nerr    = 0;
        rst_n   = 1'b0;
        iStart  = 1'b0;
        iClear  = 1'b0;
        iLen    = '0;
        iDirVec = '0;
        iReady  = 1'b1;
        #12;
        chk("rst_sobol", oSobol, 0);
        chk("rst_valid", oValid, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_lsz", oLszIdx, 0);
        rst_n = 1'b1;
        tick();

        // full period, no stalls: every value exactly once
        start_run(4'd15);
        run_beats(16, 0, -1, -1);
        chk("full_cover", seen, 16'hFFFF);

        // backpressure, same sequence
        start_run(4'd15);
        run_beats(16, 1, -1, -1);
        chk("bp_cover", seen, 16'hFFFF);

        // minimum and short lengths
        start_run(4'd0);
        run_beats(1, 0, -1, -1);
        start_run(4'd3);
        run_beats(4, 1, -1, -1);

        // iStart with new settings mid-run is ignored
        start_run(4'd7);
        run_beats(8, 0, 3, -1);

        // iClear at beat 5, then restart from 0
        start_run(4'd15);
        run_beats(16, 0, -1, 5);
        start_run(4'd2);
        run_beats(3, 0, -1, -1);

        // iClear coincident with accepted last beat: no oDone
        start_run(4'd3);
        run_beats(4, 0, -1, 3);

        // iStart and iClear together in IDLE: no run
        iStart = 1'b1;
        iClear = 1'b1;
        tick();
        iStart = 1'b0;
        iClear = 1'b0;
        chk("sc_valid", oValid, 0);
        chk("sc_busy", oBusy, 0);

        // async reset between edges mid-run
        start_run(4'd15);
        iReady = 1'b1;
        repeat (4) tick();
        chk("pre_rst_sobol", oSobol, exp_seq[4]);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", oValid, 0);
        chk("arst_busy", oBusy, 0);
        chk("arst_sobol", oSobol, 0);
        chk("arst_lsz", oLszIdx, 0);
        chk("arst_done", oDone, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_done", oDone, 0);
        start_run(4'd15);
        run_beats(16, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
